vga_scene_sequencer: RTL and testbench
======================================

# vga_scene_sequencer

Frame-synchronous scheduler for the VGA pattern datapath. Watches the pixel counters from the sync generator and steps through a host-loaded program of scenes. Each scene is a pattern ID shown for N frames. It drives the pattern-select input of the pixel-colour logic and switches it only at frame boundaries, so no frame is torn. Sits between the sync generator / host config port and the RGB pattern mux in the top-level wrapper.

## Interface

Parameters:
- `H_MAX`, 799: last hpos of a line.
- `V_MAX`, 524: last vpos of a frame.
- `DEPTH`, 8: program entries; power of two, at most 16.

Ports:
- `clk`, in, 1: pixel clock.
- `reset`, in, 1: asynchronous, active-high.
- `hpos`, in, 10: horizontal counter from the sync generator.
- `vpos`, in, 10: vertical counter from the sync generator.
- `run`, in, 1: level-sensitive sequencer enable.
- `cfg_valid`, in, 1: shadow-table write request.
- `cfg_ready`, out, 1: write accepted when `cfg_valid & cfg_ready`.
- `cfg_addr`, in, log2(DEPTH): shadow entry index.
- `cfg_data`, in, 12: `{pattern[3:0], frames[7:0]}`.
- `cfg_commit`, in, 1: single-cycle request to swap the shadow table into the active table.
- `cfg_len`, in, log2(DEPTH)+1: entry count, sampled with `cfg_commit`.
- `pattern_sel`, out, 4: registered pattern ID for the colour mux.
- `scene_idx`, out, log2(DEPTH): active entry index.
- `scene_start`, out, 1: one-cycle pulse on each scene entry.
- `commit_pending`, out, 1: a commit is waiting for the frame boundary.
- `done`, out, 1: program finished; meaningful only without the loop feature.

## Operation

- `frame_end` = (hpos == H_MAX) && (vpos == V_MAX).
- Storage: a shadow table and an active table, each DEPTH × 12 bits, plus `active_len`.
- Host writes go only to the shadow table.
- `cfg_ready` = ~`commit_pending`.
- Commit rules:
  - `cfg_commit` with 1 ≤ `cfg_len` ≤ DEPTH and no commit pending: set `commit_pending`, latch `cfg_len`.
  - Otherwise the commit is ignored.
  - `cfg_valid` and `cfg_commit` in the same cycle: the write is accepted and included in the committed table.
- At `frame_end` with a commit pending:
  - Copy shadow to active in one cycle and load `active_len`.
  - Clear `commit_pending`; `idx` = 0; `frame_cnt` = 0.
  - If `run` is high: enter RUN, load `pattern_sel` from entry 0, pulse `scene_start`.
- State machine:
  - IDLE: `pattern_sel` = 0, `done` = 0.
  - IDLE → RUN at `frame_end` when `run` = 1 and `active_len` ≠ 0. Entry 0 is loaded and `scene_start` pulses.
  - RUN, at `frame_end` with no commit pending: increment `frame_cnt`.
  - Scene advance when `frame_cnt + 1` ≥ max(`frames`, 1); a `frames` value of 0 acts as 1.
  - Non-last entry: advance to `idx + 1`, clear `frame_cnt`, pulse `scene_start`.
  - Last entry (`idx` == `active_len − 1`): behaviour is set by the configuration macro.
  - HOLD: `pattern_sel` holds the last entry, `done` = 1. Only a commit or `run` = 0 leaves HOLD.
  - `run` = 0 in any state: go to IDLE on the next clock, not frame-aligned. Counters are cleared; the active table is retained.
- Reset values:
  - All outputs 0 except `cfg_ready` = 1.
  - Both tables cleared; `active_len` = 0; state IDLE.
- Reset mid-frame: the next run starts only after a new commit and a `frame_end`.

## Timing

- Every output except `cfg_ready` is registered. `cfg_ready` is combinational from `commit_pending`.
- `pattern_sel`, `scene_idx` and `scene_start` update on the edge that samples `frame_end`. The new value is valid during pixel (0,0) of the next frame.
- Commit latency: from 1 cycle up to one full frame (H_MAX+1)·(V_MAX+1) cycles.
- `scene_start` is high for exactly 1 cycle.
- `commit_pending` rises 1 cycle after `cfg_commit` and falls on the `frame_end` edge.
- `cfg_commit` on the same cycle as `frame_end` is applied at the following frame.

## Configuration

`SCENE_LOOP_EN` sets the last-entry behaviour:
- Defined: after the last entry completes, wrap to entry 0, pulse `scene_start`, stay in RUN. `done` stays 0.
- Undefined: after the last entry completes, enter HOLD with `done` = 1.

## Structure

- Package `vga_seq_pkg` holds:
  - the scene-entry typedef (pattern 4 b, frames 8 b);
  - the state enum (IDLE, RUN, HOLD);
  - H_MAX/V_MAX defaults for 640×480.
- Sub-module `scene_table` holds the dual-bank shadow/active storage, the write port and the bulk-copy strobe. The FSM and counters stay in the top.

## Test plan

- Program {(3,2),(5,1)}, len 2, commit, run = 1 → `pattern_sel` sequence per frame: 3, 3, 5, then 3 with SCENE_LOOP_EN; 3, 3, 5, 5… with `done` = 1 without it.
- Commit mid-frame at (100,200) → `pattern_sel` unchanged until the `frame_end` edge. It changes exactly at (0,0) with a 1-cycle `scene_start`.
- `cfg_valid` while `commit_pending` → `cfg_ready` = 0 and the shadow entry is unchanged. A second `cfg_commit` during pending is ignored.
- Entry with frames = 0 → shown exactly 1 frame. `cfg_len` = 0 or `cfg_len` > DEPTH commit → `commit_pending` stays 0.
- `run` drops mid-scene → `pattern_sel` = 0 next cycle. `run` reasserted → entry 0 restarts at the next `frame_end`.
- Reset asserted mid-RUN → all outputs 0 immediately and `cfg_ready` = 1. After release, state stays IDLE despite `run` = 1 until a new commit.

Source files
------------

// File: rtl/vga_seq_pkg.sv
// Shared types and defaults for the VGA scene sequencer.
// Scene entry layout, FSM states and 640x480 timing limits.
package vga_seq_pkg;

  localparam int H_MAX_DEF = 799;
  localparam int V_MAX_DEF = 524;

  typedef struct packed {
    logic [3:0] pattern;
    logic [7:0] frames;
  } scene_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HOLD
  } state_t;

  // A frame count of zero still shows the scene once.
  function automatic logic [7:0] eff_frames(
    input logic [7:0] f
  );
    return (f == 8'd0) ? 8'd1 : f;
  endfunction

endpackage

// File: rtl/scene_table.sv
// Dual-bank scene storage: host-written shadow bank, bulk copy to active.
// Ports: wr_en/wr_addr/wr_data shadow write, copy strobe, two active reads, shadow[0].
module scene_table
  import vga_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  scene_t        wr_data,
  input  logic          copy,
  input  logic [AW-1:0] cur_addr,
  input  logic [AW-1:0] nxt_addr,
  output logic [7:0]    cur_frames,
  output logic [3:0]    nxt_pattern,
  output logic [3:0]    shd0_pattern
);

  scene_t shadow [DEPTH];
  scene_t active [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (wr_en)
        shadow[wr_addr] <= wr_data;
      if (copy)
        for (int i = 0; i < DEPTH; i++)
          active[i] <= shadow[i];
    end
  end

  assign cur_frames   = active[cur_addr].frames;
  assign nxt_pattern  = active[nxt_addr].pattern;
  // Entry 0 of the incoming program, needed on the copy edge itself.
  assign shd0_pattern = shadow[0].pattern;

endmodule

// File: rtl/vga_scene_sequencer.sv
// Frame-synchronous scene scheduler driving the pattern-select of the colour mux.
// Ports: hpos/vpos in, run, cfg_* host port, pattern_sel/scene_idx/scene_start/
// commit_pending/done out. SCENE_LOOP_EN: wrap to entry 0 instead of holding.
module vga_scene_sequencer
  import vga_seq_pkg::*;
#(
  parameter int H_MAX = H_MAX_DEF,
  parameter int V_MAX = V_MAX_DEF,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [9:0]    hpos,
  input  logic [9:0]    vpos,
  input  logic          run,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [AW-1:0] cfg_addr,
  input  logic [11:0]   cfg_data,
  input  logic          cfg_commit,
  input  logic [AW:0]   cfg_len,
  output logic [3:0]    pattern_sel,
  output logic [AW-1:0] scene_idx,
  output logic          scene_start,
  output logic          commit_pending,
  output logic          done
);

  state_t        state;
  logic [AW-1:0] idx;
  logic [7:0]    frame_cnt;
  logic [AW:0]   active_len;
  logic [AW:0]   pend_len;

  logic          frame_end;
  logic          copy;
  logic          len_ok;
  logic          last;
  logic          scene_done;
  logic [AW-1:0] nxt_addr;
  logic [7:0]    cur_frames;
  logic [3:0]    nxt_pattern;
  logic [3:0]    shd0_pattern;

  assign frame_end = (hpos == 10'(H_MAX)) &&
                     (vpos == 10'(V_MAX));
  assign copy      = frame_end & commit_pending;
  assign cfg_ready = ~commit_pending;
  assign scene_idx = idx;

  assign len_ok = (cfg_len != '0) &&
                  (cfg_len <= (AW+1)'(DEPTH));

  assign last = ({1'b0, idx} ==
                 active_len - (AW+1)'(1));

  assign scene_done =
    ({1'b0, frame_cnt} + 9'd1) >=
    {1'b0, eff_frames(cur_frames)};

  // Next entry to show: idx+1 mid-program, else entry 0.
  assign nxt_addr = (state == S_RUN && !last) ?
                    idx + AW'(1) : '0;

  scene_table #(.DEPTH(DEPTH)) u_table (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (cfg_valid & cfg_ready),
    .wr_addr      (cfg_addr),
    .wr_data      (cfg_data),
    .copy         (copy),
    .cur_addr     (idx),
    .nxt_addr     (nxt_addr),
    .cur_frames   (cur_frames),
    .nxt_pattern  (nxt_pattern),
    .shd0_pattern (shd0_pattern)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      commit_pending <= 1'b0;
      pend_len       <= '0;
      active_len     <= '0;
    end else if (copy) begin
      commit_pending <= 1'b0;
      active_len     <= pend_len;
    end else if (cfg_commit && len_ok &&
                 !commit_pending) begin
      commit_pending <= 1'b1;
      pend_len       <= cfg_len;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      idx         <= '0;
      frame_cnt   <= '0;
      pattern_sel <= '0;
      scene_start <= 1'b0;
      done        <= 1'b0;
    end else begin
      scene_start <= 1'b0;
      if (!run) begin
        state       <= S_IDLE;
        idx         <= '0;
        frame_cnt   <= '0;
        pattern_sel <= '0;
        done        <= 1'b0;
      end else if (copy) begin
        state       <= S_RUN;
        idx         <= '0;
        frame_cnt   <= '0;
        pattern_sel <= shd0_pattern;
        scene_start <= 1'b1;
        done        <= 1'b0;
      end else if (frame_end) begin
        unique case (state)
          S_IDLE: begin
            if (active_len != '0) begin
              state       <= S_RUN;
              idx         <= '0;
              frame_cnt   <= '0;
              pattern_sel <= nxt_pattern;
              scene_start <= 1'b1;
            end
          end
          S_RUN: begin
            if (!scene_done) begin
              frame_cnt <= frame_cnt + 8'd1;
            end else if (!last) begin
              idx         <= idx + AW'(1);
              frame_cnt   <= '0;
              pattern_sel <= nxt_pattern;
              scene_start <= 1'b1;
            end else begin
`ifdef SCENE_LOOP_EN
              idx         <= '0;
              frame_cnt   <= '0;
              pattern_sel <= nxt_pattern;
              scene_start <= 1'b1;
`else
              state <= S_HOLD;
              done  <= 1'b1;
`endif
            end
          end
          S_HOLD: state <= S_HOLD;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_scene_sequencer.sv
// Self-checking bench for vga_scene_sequencer on a shrunken 16x8 frame.
// Scene-level reference model plus directed per-frame expectations.
module tb_vga_scene_sequencer;

  localparam int HM = 15;
  localparam int VM = 7;
  localparam int D  = 8;
  localparam int FR = (HM + 1) * (VM + 1);

  logic       clk;
  logic       reset;
  logic [9:0] hcnt = '0;
  logic [9:0] vcnt = '0;
  logic       run;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [2:0] cfg_addr;
  logic [11:0] cfg_data;
  logic       cfg_commit;
  logic [3:0] cfg_len;
  logic [3:0] pattern_sel;
  logic [2:0] scene_idx;
  logic       scene_start;
  logic       commit_pending;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;

  vga_scene_sequencer #(
    .H_MAX(HM), .V_MAX(VM), .DEPTH(D)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .hpos           (hcnt),
    .vpos           (vcnt),
    .run            (run),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_addr       (cfg_addr),
    .cfg_data       (cfg_data),
    .cfg_commit     (cfg_commit),
    .cfg_len        (cfg_len),
    .pattern_sel    (pattern_sel),
    .scene_idx      (scene_idx),
    .scene_start    (scene_start),
    .commit_pending (commit_pending),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running sync-generator stand-in.
  always @(posedge clk) begin
    if (hcnt == HM) begin
      hcnt <= '0;
      vcnt <= (vcnt == VM) ? '0 : vcnt + 10'd1;
    end else begin
      hcnt <= hcnt + 10'd1;
    end
  end

  // Reference model: tables, pending commit, and a
  // countdown of frames left in the current scene.
  bit [11:0] m_sh [D];
  bit [11:0] m_ac [D];
  int  m_alen, m_plen, m_st, m_idx, m_left;
  bit  m_pend, m_start, m_done;
  int  m_pat;
  bit  fe, cp, nc;

  task automatic enter_scene(input int i);
    m_st    = 1;
    m_idx   = i;
    m_left  = (m_ac[i][7:0] == 0) ? 1 : m_ac[i][7:0];
    m_pat   = m_ac[i][11:8];
    m_start = 1;
    m_done  = 0;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < D; i++) begin
        m_sh[i] = '0;
        m_ac[i] = '0;
      end
      m_alen = 0; m_plen = 0; m_st = 0;
      m_idx = 0; m_left = 0; m_pend = 0;
      m_start = 0; m_done = 0; m_pat = 0;
    end else begin
      fe = (hcnt == HM) && (vcnt == VM);
      cp = fe && m_pend;
      nc = cfg_commit && !m_pend &&
           cfg_len >= 1 && cfg_len <= D;
      if (cfg_valid && !m_pend)
        m_sh[cfg_addr] = cfg_data;
      if (cp) begin
        for (int i = 0; i < D; i++)
          m_ac[i] = m_sh[i];
        m_alen = m_plen;
        m_pend = 0;
      end
      if (nc) begin
        m_pend = 1;
        m_plen = int'(cfg_len);
      end
      m_start = 0;
      if (!run) begin
        m_st = 0; m_pat = 0;
        m_done = 0; m_idx = 0;
      end else if (cp ||
                   (fe && m_st == 0 && m_alen != 0)) begin
        enter_scene(0);
      end else if (fe && m_st == 1) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          if (m_idx + 1 < m_alen) begin
            enter_scene(m_idx + 1);
          end else begin
`ifdef SCENE_LOOP_EN
            enter_scene(0);
`else
            m_st = 2;
            m_done = 1;
`endif
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      n_cmp++;
      if (pattern_sel !== 4'(m_pat) ||
          scene_idx !== 3'(m_idx) ||
          scene_start !== m_start ||
          commit_pending !== m_pend ||
          done !== m_done ||
          cfg_ready !== !m_pend) begin
        n_bad++;
        $display("FAIL cycle t=%0t got pat=%0d idx=%0d st=%0b pend=%0b done=%0b rdy=%0b want pat=%0d idx=%0d st=%0b pend=%0b done=%0b rdy=%0b",
          $time, pattern_sel, scene_idx, scene_start,
          commit_pending, done, cfg_ready, m_pat, m_idx,
          m_start, m_pend, m_done, !m_pend);
      end
    end
  end

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic wait_pos(input int x, input int y);
    int  k;
    bit  hit;
    k = 0;
    hit = 0;
    while (!hit && k < 4 * FR) begin
      @(posedge clk);
      #1;
      k++;
      hit = (hcnt == x) && (vcnt == y);
    end
    if (!hit) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_pos timeout at (%0d,%0d)", x, y);
    end
  endtask

  task automatic wait_fs();
    int  k;
    bit  hit;
    k = 0;
    hit = 0;
    while (!hit && k < 4 * FR) begin
      @(negedge clk);
      k++;
      hit = (hcnt == 0) && (vcnt == 0);
    end
    if (!hit) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_fs timeout");
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    run = 1'b0;
    cfg_valid = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    cfg_commit = 1'b0;
    cfg_len = '0;
    repeat (3) tick();
    chk("rst_pat", pattern_sel, 0);
    chk("rst_rdy", cfg_ready, 1);
    chk("rst_pend", commit_pending, 0);
    chk("rst_done", done, 0);
    chk("rst_start", scene_start, 0);
    reset = 1'b0;
    run = 1'b1;

    // Program {(3,2),(5,1)}; last write shares the commit cycle.
    cfg_valid = 1; cfg_addr = 0; cfg_data = {4'd3, 8'd2};
    tick();
    cfg_valid = 0;
    wait_pos(10, 5);
    cfg_valid = 1; cfg_addr = 1; cfg_data = {4'd5, 8'd1};
    cfg_commit = 1; cfg_len = 2;
    tick();
    cfg_valid = 0; cfg_commit = 0;
    chk("pend_rise", commit_pending, 1);
    chk("rdy_low", cfg_ready, 0);
    chk("pat_before_fe", pattern_sel, 0);
    wait_fs();
    chk("f1_pat", pattern_sel, 3);
    chk("f1_start", scene_start, 1);
    chk("f1_pend", commit_pending, 0);
    wait_fs();
    chk("f2_pat", pattern_sel, 3);
    chk("f2_start", scene_start, 0);
    wait_fs();
    chk("f3_pat", pattern_sel, 5);
    chk("f3_idx", scene_idx, 1);
    wait_fs();
`ifdef SCENE_LOOP_EN
    chk("f4_pat", pattern_sel, 3);
    chk("f4_done", done, 0);
`else
    chk("f4_pat", pattern_sel, 5);
    chk("f4_done", done, 1);
`endif

    // Program {(7,0),(2,1)}; blocked write and commit while pending.
    wait_pos(2, 1);
    cfg_valid = 1; cfg_addr = 0; cfg_data = {4'd7, 8'd0};
    tick();
    cfg_addr = 1; cfg_data = {4'd2, 8'd1};
    cfg_commit = 1; cfg_len = 2;
    tick();
    cfg_addr = 0; cfg_data = {4'd9, 8'd4};
    cfg_commit = 1; cfg_len = 1;
    chk("busy_rdy", cfg_ready, 0);
    tick();
    cfg_valid = 0; cfg_commit = 0;
    chk("busy_pend", commit_pending, 1);
    wait_fs();
    chk("g1_pat", pattern_sel, 7);
    chk("g1_done", done, 0);
    wait_fs();
    chk("g2_pat", pattern_sel, 2);
    chk("g2_start", scene_start, 1);
    wait_fs();
`ifdef SCENE_LOOP_EN
    chk("g3_pat", pattern_sel, 7);
`else
    chk("g3_pat", pattern_sel, 2);
    chk("g3_done", done, 1);
`endif

    // Out-of-range commit lengths.
    wait_pos(4, 2);
    cfg_commit = 1; cfg_len = 0;
    tick();
    cfg_commit = 0;
    chk("len0_pend", commit_pending, 0);
    cfg_commit = 1; cfg_len = 9;
    tick();
    cfg_commit = 0;
    chk("len9_pend", commit_pending, 0);

    // run drop and restart.
    wait_pos(6, 3);
    run = 0;
    tick();
    chk("stop_pat", pattern_sel, 0);
    chk("stop_done", done, 0);
    tick();
    run = 1;
    wait_fs();
    chk("restart_pat", pattern_sel, 7);
    chk("restart_start", scene_start, 1);

    // Reset mid-run.
    wait_pos(5, 4);
    reset = 1;
    #1;
    chk("mrst_pat", pattern_sel, 0);
    chk("mrst_rdy", cfg_ready, 1);
    chk("mrst_idx", scene_idx, 0);
    tick();
    reset = 0;
    wait_fs();
    chk("post_rst_pat1", pattern_sel, 0);
    wait_fs();
    chk("post_rst_pat2", pattern_sel, 0);
    chk("post_rst_start", scene_start, 0);

    // Fresh single-entry program after reset.
    wait_pos(1, 1);
    cfg_valid = 1; cfg_addr = 0; cfg_data = {4'd4, 8'd1};
    cfg_commit = 1; cfg_len = 1;
    tick();
    cfg_valid = 0; cfg_commit = 0;
    wait_fs();
    chk("h1_pat", pattern_sel, 4);
    chk("h1_start", scene_start, 1);
    wait_fs();
    chk("h2_pat", pattern_sel, 4);
`ifndef SCENE_LOOP_EN
    chk("h2_done", done, 1);
`endif
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
